// File: rtl/rr_mux_arb.sv
// N-channel registered selector with valid/ready handshake, round-robin or fixed-priority arbitration.
// Optional packet locking (in_last/out_last) is enabled by defining RR_MUX_LOCK_EN.
module rr_mux_arb #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mode,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic [CHANNELS-1:0]       in_ready,
`ifdef RR_MUX_LOCK_EN
  input  logic [CHANNELS-1:0]       in_last,
  output logic                      out_last,
`endif
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_sel,
  input  logic                      out_ready
);

  logic                out_valid_q, out_valid_d;
  logic [WIDTH-1:0]    out_data_q, out_data_d;
  logic [SEL_W-1:0]    out_sel_q, out_sel_d;
  logic [SEL_W-1:0]    ptr_q, ptr_d;
`ifdef RR_MUX_LOCK_EN
  logic                out_last_q, out_last_d;
  logic                locked_q, locked_d;
  logic [SEL_W-1:0]    lock_ch_q, lock_ch_d;
`endif

  logic                load_c;
  logic                grant_any_c;
  logic [SEL_W-1:0]    grant_idx_c;
  logic [SEL_W-1:0]    rr_idx_c;
  logic [CHANNELS-1:0] elig_c;
  logic [CHANNELS-1:0] grant_c;
  logic [WIDTH-1:0]    grant_word_c;

  // Arbitration: pick one eligible channel, starting after ptr in round-robin mode.
  always_comb begin
    load_c      = !out_valid_q || out_ready;
    elig_c      = in_valid;
`ifdef RR_MUX_LOCK_EN
    if (locked_q) begin
      elig_c = in_valid & (CHANNELS'(1) << lock_ch_q);
    end
`endif
    grant_any_c = 1'b0;
    grant_idx_c = '0;
    rr_idx_c    = ptr_q;
    if (mode) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (!grant_any_c && elig_c[SEL_W'(i)]) begin
          grant_any_c = 1'b1;
          grant_idx_c = SEL_W'(i);
        end
      end
    end else begin
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        // Explicit wrap keeps non-power-of-two channel counts free of phantom slots.
        rr_idx_c = (rr_idx_c == SEL_W'(CHANNELS - 1)) ? '0 : rr_idx_c + SEL_W'(1);
        if (!grant_any_c && elig_c[rr_idx_c]) begin
          grant_any_c = 1'b1;
          grant_idx_c = rr_idx_c;
        end
      end
    end

    grant_word_c = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (grant_idx_c == SEL_W'(i)) begin
        grant_word_c = in_data[i*WIDTH +: WIDTH];
      end
    end

    grant_c  = grant_any_c ? (CHANNELS'(1) << grant_idx_c) : '0;
    in_ready = (load_c && !rst) ? grant_c : '0;
  end

  // Next-state for the output register, pointer and lock.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
`ifdef RR_MUX_LOCK_EN
    out_last_d  = out_last_q;
    locked_d    = locked_q;
    lock_ch_d   = lock_ch_q;
`endif
    if (load_c) begin
      out_valid_d = grant_any_c;
      if (grant_any_c) begin
        out_data_d = grant_word_c;
        out_sel_d  = grant_idx_c;
        if (!mode) begin
          ptr_d = grant_idx_c;
        end
`ifdef RR_MUX_LOCK_EN
        out_last_d = in_last[grant_idx_c];
        locked_d   = !in_last[grant_idx_c];
        lock_ch_d  = grant_idx_c;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= SEL_W'(CHANNELS - 1);
`ifdef RR_MUX_LOCK_EN
      out_last_q  <= 1'b0;
      locked_q    <= 1'b0;
      lock_ch_q   <= '0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
`ifdef RR_MUX_LOCK_EN
      out_last_q  <= out_last_d;
      locked_q    <= locked_d;
      lock_ch_q   <= lock_ch_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
`ifdef RR_MUX_LOCK_EN
  assign out_last  = out_last_q;
`endif

endmodule

// File: tb/tb_rr_mux_arb.sv
// Directed bench for rr_mux_arb: 4-channel vector table, 3-channel wrap sequence,
// asynchronous reset mid-stream and (with RR_MUX_LOCK_EN) packet locking.
module tb_rr_mux_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode;
  logic [3:0]  in_valid;
  logic [127:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic [1:0]  out_sel;
  logic        out_ready;
  logic [3:0]  in_last;
  logic        out_last;

  logic        mode3;
  logic [2:0]  in_valid3;
  logic [95:0] in_data3;
  logic [2:0]  in_ready3;
  logic        out_valid3;
  logic [31:0] out_data3;
  logic [1:0]  out_sel3;
  logic        out_ready3;
  logic [2:0]  in_last3;
  logic        out_last3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rr_mux_arb #(.WIDTH(32), .CHANNELS(4)) dut (
    .clk(clk), .rst(rst), .mode(mode),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
`ifdef RR_MUX_LOCK_EN
    .in_last(in_last), .out_last(out_last),
`endif
    .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel), .out_ready(out_ready)
  );

  rr_mux_arb #(.WIDTH(32), .CHANNELS(3)) dut3 (
    .clk(clk), .rst(rst), .mode(mode3),
    .in_valid(in_valid3), .in_data(in_data3), .in_ready(in_ready3),
`ifdef RR_MUX_LOCK_EN
    .in_last(in_last3), .out_last(out_last3),
`endif
    .out_valid(out_valid3), .out_data(out_data3), .out_sel(out_sel3), .out_ready(out_ready3)
  );

`ifndef RR_MUX_LOCK_EN
  assign out_last  = 1'b0;
  assign out_last3 = 1'b0;
`endif

  typedef struct {
    logic        mode;
    logic [3:0]  valid;
    logic [3:0]  last;
    logic        ordy;
    logic [3:0]  exp_rdy;
    logic        exp_ov;
    logic [1:0]  exp_sel;
    logic [31:0] exp_data;
    logic        chk_last;
    logic        exp_last;
  } vec_t;

  vec_t vt[64];
  int   nv = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic m, input logic [3:0] v, input logic r, input logic [3:0] er,
                     input logic eov, input logic [1:0] es);
    vt[nv].mode     = m;
    vt[nv].valid    = v;
    vt[nv].last     = 4'hf;
    vt[nv].ordy     = r;
    vt[nv].exp_rdy  = er;
    vt[nv].exp_ov   = eov;
    vt[nv].exp_sel  = es;
    vt[nv].exp_data = 32'h1000 + 32'(es);
    vt[nv].chk_last = 1'b0;
    vt[nv].exp_last = 1'b0;
    nv++;
  endtask

  task automatic add_lock(input logic [3:0] v, input logic [3:0] l, input logic [3:0] er,
                          input logic eov, input logic [1:0] es, input logic el);
    add(1'b0, v, 1'b1, er, eov, es);
    vt[nv-1].last     = l;
    vt[nv-1].chk_last = 1'b1;
    vt[nv-1].exp_last = el;
  endtask

  // Drive at negedge, check in_ready before the edge and outputs after it.
  task automatic run_vec(input int i);
    @(negedge clk);
    mode      = vt[i].mode;
    in_valid  = vt[i].valid;
    in_last   = vt[i].last;
    out_ready = vt[i].ordy;
    #1;
    chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vt[i].exp_rdy));
    @(posedge clk);
    #1;
    chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vt[i].exp_ov));
    chk($sformatf("v%0d out_sel", i), 32'(out_sel), 32'(vt[i].exp_sel));
    chk($sformatf("v%0d out_data", i), out_data, vt[i].exp_data);
    if (vt[i].chk_last) chk($sformatf("v%0d out_last", i), 32'(out_last), 32'(vt[i].exp_last));
  endtask

  task automatic step3(input logic [2:0] v, input logic [2:0] er, input logic [1:0] es);
    @(negedge clk);
    in_valid3 = v;
    #1;
    chk("c3 in_ready", 32'(in_ready3), 32'(er));
    @(posedge clk);
    #1;
    chk("c3 out_valid", 32'(out_valid3), 32'd1);
    chk("c3 out_sel", 32'(out_sel3), 32'(es));
    chk("c3 out_data", out_data3, 32'h1000 + 32'(es));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = 32'h1000 + 32'(i);
    for (int i = 0; i < 3; i++) in_data3[i*32 +: 32] = 32'h1000 + 32'(i);
    rst = 1'b1; mode = 1'b0; in_valid = 4'hf; in_last = 4'hf; out_ready = 1'b1;
    mode3 = 1'b0; in_valid3 = 3'b000; in_last3 = 3'b111; out_ready3 = 1'b1;

    // Vector table: round-robin, fixed priority, backpressure, sparse/wrap, mode switch.
    for (int k = 0; k < 5; k++) add(1'b0, 4'hf, 1'b1, 4'b0001 << (k % 4), 1'b1, 2'(k % 4));
    for (int k = 0; k < 4; k++) add(1'b1, 4'hf, 1'b1, 4'b0001, 1'b1, 2'd0);
    add(1'b0, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2);
    for (int k = 0; k < 5; k++) add(1'b0, 4'hf, 1'b0, 4'b0000, 1'b1, 2'd2);
    add(1'b0, 4'hf, 1'b1, 4'b1000, 1'b1, 2'd3);
    add(1'b0, 4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1);
    add(1'b0, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0);
    add(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0);
    add(1'b1, 4'b1100, 1'b1, 4'b0100, 1'b1, 2'd2);
    add(1'b0, 4'b1110, 1'b1, 4'b0010, 1'b1, 2'd1);
    add(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1);
    add(1'b0, 4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2);
    add(1'b0, 4'b1000, 1'b0, 4'b0000, 1'b1, 2'd2);

    // Reset state with every channel requesting: nothing may be accepted.
    #12;
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst out_data", out_data, 32'd0);
    chk("rst out_sel", 32'(out_sel), 32'd0);
    chk("rst in_ready", 32'(in_ready), 32'd0);
    chk("rst out_last", 32'(out_last), 32'd0);
    @(negedge clk);
    in_valid = 4'h0;
    rst = 1'b0;

    for (int i = 0; i < nv; i++) run_vec(i);

    // Three channels: pointer wraps 2 -> 0 with no phantom slot.
    step3(3'b100, 3'b100, 2'd2);
    step3(3'b011, 3'b001, 2'd0);
    step3(3'b101, 3'b100, 2'd2);
    step3(3'b111, 3'b001, 2'd0);
    step3(3'b110, 3'b010, 2'd1);

    // Asynchronous reset while a beat is buffered.
    @(negedge clk);
    mode = 1'b0; in_valid = 4'hf; out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("pre-rst out_valid", 32'(out_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async rst out_valid", 32'(out_valid), 32'd0);
    chk("async rst out_data", out_data, 32'd0);
    chk("async rst out_sel", 32'(out_sel), 32'd0);
    chk("async rst in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post-rst in_ready", 32'(in_ready), 32'b0001);

`ifdef RR_MUX_LOCK_EN
    // Channel 1 sends a 3-beat packet with one idle cycle; channel 2 must wait.
    do_reset();
    nv = 0;
    add_lock(4'b0110, 4'b0000, 4'b0010, 1'b1, 2'd1, 1'b0);
    add_lock(4'b0100, 4'b0000, 4'b0000, 1'b0, 2'd1, 1'b0);
    add_lock(4'b0110, 4'b0000, 4'b0010, 1'b1, 2'd1, 1'b0);
    add_lock(4'b0110, 4'b0010, 4'b0010, 1'b1, 2'd1, 1'b1);
    add_lock(4'b0100, 4'b0000, 4'b0100, 1'b1, 2'd2, 1'b0);
    add_lock(4'b0010, 4'b0010, 4'b0000, 1'b0, 2'd2, 1'b0);
    for (int i = 0; i < nv; i++) run_vec(i);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
